design_1_top: RTL and testbench

// - Self-contained AXI4-Lite register subsystem: AXI VIP master drives a word-addressed register bank.
// - Only clock and reset are external; the bench drives traffic through the VIP agent by hierarchy.
// - Instance names are fixed: axi_vip_0 (VIP, interface at axi_vip_0.inst.IF).
// - axi4_lite_wrapper_v2_0 (wrapper), with its register core at axi4_lite_wrapper_v2_0.inst.

---
 rtl/design_1_pkg.sv | 30 +++
 rtl/design_1_if.sv | 41 ++++
 rtl/design_1_regs.sv | 140 ++++++++++++++
 rtl/design_1_top.sv | 118 +++++++++++
 tb/tb_design_1_top.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/design_1_pkg.sv
// Shared definitions for the design_1 AXI4-Lite register subsystem.
// Contents: bus widths, response codes, default register count and the
// byte-lane merge helper used when DESIGN_1_WSTRB_EN is defined.
package design_1_pkg;

    localparam int DATA_W        = 32;
    localparam int STRB_W        = DATA_W / 8;
    localparam int ADDR_LSB      = 2;
    localparam int DEF_REGISTERS = 16;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10
    } axi_resp_t;

    // Replace only the byte lanes whose strobe bit is set.
    function automatic logic [DATA_W-1:0] apply_wstrb(
        input logic [DATA_W-1:0] old_word,
        input logic [DATA_W-1:0] new_word,
        input logic [STRB_W-1:0] strb
    );
        logic [DATA_W-1:0] merged;
        merged = old_word;
        for (int k = 0; k < STRB_W; k++) begin
            if (strb[k]) merged[8*k +: 8] = new_word[8*k +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/design_1_if.sv
// AXI4-Lite bus bundle for design_1.
// Modports: master (drives AW/W/AR valids, payload, bready, rready)
//           slave  (drives readies, B and R channels).
interface design_1_if
    import design_1_pkg::*;
#(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] awaddr;
    logic [2:0]        awprot;
    logic              awvalid;
    logic              awready;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              wvalid;
    logic              wready;
    axi_resp_t         bresp;
    logic              bvalid;
    logic              bready;
    logic [ADDR_W-1:0] araddr;
    logic [2:0]        arprot;
    logic              arvalid;
    logic              arready;
    logic [DATA_W-1:0] rdata;
    axi_resp_t         rresp;
    logic              rvalid;
    logic              rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

endinterface

// File: rtl/design_1_regs.sv
// axi4_lite_regs: word-addressed register bank behind an AXI4-Lite slave.
// Ports: aclk, aresetn (async assert, active low), s_axi (design_1_if.slave).
// Build option: DESIGN_1_WSTRB_EN enables per-byte write strobes; without it
// every accepted in-range write replaces the whole word.
module axi4_lite_regs
    import design_1_pkg::*;
#(
    parameter int                REGISTERS = DEF_REGISTERS,
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input logic       aclk,
    input logic       aresetn,
    design_1_if.slave s_axi
);
    localparam int IDX_W = $clog2(REGISTERS);

    typedef enum logic [2:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_COMMIT, W_RESP} wr_state_t;
    typedef enum logic {R_IDLE, R_DATA} rd_state_t;

    wr_state_t         wr_state, wr_next;
    rd_state_t         rd_state, rd_next;
    logic              ready_en;
    logic [DATA_W-1:0] regs [REGISTERS];
    logic [IDX_W-1:0]  aw_idx;
    logic              aw_ok;
    logic [DATA_W-1:0] w_data;
    logic [STRB_W-1:0] w_strb;
    axi_resp_t         bresp_q, rresp_q;
    logic [DATA_W-1:0] rdata_q;
    logic [ADDR_W-1:0] aw_word, ar_word;
    logic              aw_take, w_take, ar_take;

    // Word index relative to the base; the low two byte-address bits drop out.
    assign aw_word = (s_axi.awaddr - BASE_ADDR) >> ADDR_LSB;
    assign ar_word = (s_axi.araddr - BASE_ADDR) >> ADDR_LSB;

    // ready_en keeps all readies low until the first clock after reset release.
    assign s_axi.awready = ready_en && (wr_state == W_IDLE || wr_state == W_HAVE_W);
    assign s_axi.wready  = ready_en && (wr_state == W_IDLE || wr_state == W_HAVE_AW);
    assign s_axi.bvalid  = (wr_state == W_RESP);
    assign s_axi.bresp   = bresp_q;
    assign s_axi.arready = ready_en && (rd_state == R_IDLE);
    assign s_axi.rvalid  = (rd_state == R_DATA);
    assign s_axi.rdata   = rdata_q;
    assign s_axi.rresp   = rresp_q;

    assign aw_take = s_axi.awvalid && s_axi.awready;
    assign w_take  = s_axi.wvalid && s_axi.wready;
    assign ar_take = s_axi.arvalid && s_axi.arready;

    logic unused_prot;
    assign unused_prot = ^{s_axi.awprot, s_axi.arprot};

    always_comb begin
        wr_next = wr_state;
        case (wr_state)
            W_IDLE: begin
                if (aw_take && w_take) wr_next = W_COMMIT;
                else if (aw_take)      wr_next = W_HAVE_AW;
                else if (w_take)       wr_next = W_HAVE_W;
            end
            W_HAVE_AW: if (w_take)  wr_next = W_COMMIT;
            W_HAVE_W:  if (aw_take) wr_next = W_COMMIT;
            W_COMMIT:  wr_next = W_RESP;
            W_RESP:    if (s_axi.bready) wr_next = W_IDLE;
            default:   wr_next = W_IDLE;
        endcase
    end

    always_comb begin
        rd_next = rd_state;
        case (rd_state)
            R_IDLE:  if (ar_take) rd_next = R_DATA;
            R_DATA:  if (s_axi.rready) rd_next = R_IDLE;
            default: rd_next = R_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_state <= W_IDLE;
            rd_state <= R_IDLE;
            ready_en <= 1'b0;
        end else begin
            wr_state <= wr_next;
            rd_state <= rd_next;
            ready_en <= 1'b1;
        end
    end

    // The register write lands at the end of the COMMIT cycle, so a read
    // accepted in that same cycle still samples the old contents.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < REGISTERS; i++) regs[i] <= '0;
            aw_idx  <= '0;
            aw_ok   <= 1'b0;
            w_data  <= '0;
            w_strb  <= '0;
            bresp_q <= OKAY;
            rresp_q <= OKAY;
            rdata_q <= '0;
        end else begin
            if (aw_take) begin
                aw_idx <= aw_word[IDX_W-1:0];
                aw_ok  <= (aw_word < ADDR_W'(REGISTERS));
            end
            if (w_take) begin
                w_data <= s_axi.wdata;
                w_strb <= s_axi.wstrb;
            end
            if (wr_state == W_COMMIT) begin
                bresp_q <= aw_ok ? OKAY : SLVERR;
                if (aw_ok) begin
`ifdef DESIGN_1_WSTRB_EN
                    regs[aw_idx] <= apply_wstrb(regs[aw_idx], w_data, w_strb);
`else
                    regs[aw_idx] <= w_data;
`endif
                end
            end
            if (ar_take) begin
                if (ar_word < ADDR_W'(REGISTERS)) begin
                    rdata_q <= regs[ar_word[IDX_W-1:0]];
                    rresp_q <= OKAY;
                end else begin
                    rdata_q <= '0;
                    rresp_q <= SLVERR;
                end
            end
        end
    end

`ifndef DESIGN_1_WSTRB_EN
    logic unused_strb;
    assign unused_strb = ^w_strb;
`endif

endmodule

// File: rtl/design_1_top.sv
// design_1_top: self-contained AXI4-Lite register subsystem.
// Ports: aclk (single clock), aresetn (async assert, active low).
// Hierarchy: axi_vip_0 (master agent, bus visible at axi_vip_0.inst.IF) drives
// axi4_lite_wrapper_v2_0, whose register core is axi4_lite_wrapper_v2_0.inst.
// Build option: DESIGN_1_WSTRB_EN (byte strobes) is honoured in the core.

// Master agent shell: the bench drives the bus through inst.IF.
module axi_vip_master_core (design_1_if.master IF);
endmodule

module axi_vip_master (design_1_if.master m_axi);
    axi_vip_master_core inst (.IF(m_axi));
endmodule

// Wrapper: flat s_axi_* ports mapped onto the register core's bus.
module axi4_lite_wrapper
    import design_1_pkg::*;
#(
    parameter int                REGISTERS = DEF_REGISTERS,
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic [ADDR_W-1:0] s_axi_awaddr,
    input  logic [2:0]        s_axi_awprot,
    input  logic              s_axi_awvalid,
    output logic              s_axi_awready,
    input  logic [DATA_W-1:0] s_axi_wdata,
    input  logic [STRB_W-1:0] s_axi_wstrb,
    input  logic              s_axi_wvalid,
    output logic              s_axi_wready,
    output axi_resp_t         s_axi_bresp,
    output logic              s_axi_bvalid,
    input  logic              s_axi_bready,
    input  logic [ADDR_W-1:0] s_axi_araddr,
    input  logic [2:0]        s_axi_arprot,
    input  logic              s_axi_arvalid,
    output logic              s_axi_arready,
    output logic [DATA_W-1:0] s_axi_rdata,
    output axi_resp_t         s_axi_rresp,
    output logic              s_axi_rvalid,
    input  logic              s_axi_rready
);
    design_1_if #(.ADDR_W(ADDR_W)) bus ();

    assign bus.awaddr  = s_axi_awaddr;
    assign bus.awprot  = s_axi_awprot;
    assign bus.awvalid = s_axi_awvalid;
    assign bus.wdata   = s_axi_wdata;
    assign bus.wstrb   = s_axi_wstrb;
    assign bus.wvalid  = s_axi_wvalid;
    assign bus.bready  = s_axi_bready;
    assign bus.araddr  = s_axi_araddr;
    assign bus.arprot  = s_axi_arprot;
    assign bus.arvalid = s_axi_arvalid;
    assign bus.rready  = s_axi_rready;

    assign s_axi_awready = bus.awready;
    assign s_axi_wready  = bus.wready;
    assign s_axi_bresp   = bus.bresp;
    assign s_axi_bvalid  = bus.bvalid;
    assign s_axi_arready = bus.arready;
    assign s_axi_rdata   = bus.rdata;
    assign s_axi_rresp   = bus.rresp;
    assign s_axi_rvalid  = bus.rvalid;

    axi4_lite_regs #(
        .REGISTERS(REGISTERS),
        .ADDR_W   (ADDR_W),
        .BASE_ADDR(BASE_ADDR)
    ) inst (
        .aclk   (aclk),
        .aresetn(aresetn),
        .s_axi  (bus)
    );
endmodule

module design_1_top #(
    parameter int                REGISTERS = 16,
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input logic aclk,
    input logic aresetn
);
    design_1_if #(.ADDR_W(ADDR_W)) axi_bus ();

    axi_vip_master axi_vip_0 (.m_axi(axi_bus));

    axi4_lite_wrapper #(
        .REGISTERS(REGISTERS),
        .ADDR_W   (ADDR_W),
        .BASE_ADDR(BASE_ADDR)
    ) axi4_lite_wrapper_v2_0 (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .s_axi_awaddr (axi_bus.awaddr),
        .s_axi_awprot (axi_bus.awprot),
        .s_axi_awvalid(axi_bus.awvalid),
        .s_axi_awready(axi_bus.awready),
        .s_axi_wdata  (axi_bus.wdata),
        .s_axi_wstrb  (axi_bus.wstrb),
        .s_axi_wvalid (axi_bus.wvalid),
        .s_axi_wready (axi_bus.wready),
        .s_axi_bresp  (axi_bus.bresp),
        .s_axi_bvalid (axi_bus.bvalid),
        .s_axi_bready (axi_bus.bready),
        .s_axi_araddr (axi_bus.araddr),
        .s_axi_arprot (axi_bus.arprot),
        .s_axi_arvalid(axi_bus.arvalid),
        .s_axi_arready(axi_bus.arready),
        .s_axi_rdata  (axi_bus.rdata),
        .s_axi_rresp  (axi_bus.rresp),
        .s_axi_rvalid (axi_bus.rvalid),
        .s_axi_rready (axi_bus.rready)
    );
endmodule

// File: tb/tb_design_1_top.sv
// Bench for design_1_top: drives AXI4-Lite traffic through axi_vip_0.inst.IF
// and compares read data against a scoreboard of expected values.
module tb_design_1_top;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    design_1_top dut (.aclk(clk), .aresetn(rst_n));

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } rd_exp_t;

    rd_exp_t     sb [$];
    logic [31:0] model [16];
    int          tests   = 0;
    int          fails   = 0;
    int          b_count = 0;
    int          r_count = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got 0x%08h, want 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = n;
`ifdef DESIGN_1_WSTRB_EN
        r = o;
        for (int k = 0; k < 4; k++) if (s[k]) r[8*k +: 8] = n[8*k +: 8];
`else
        if (s == 4'hF && o == n) r = n;
`endif
        return r;
    endfunction

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int aw_dly, input int w_dly,
                             output logic [1:0] resp, output bit ok);
        bit aw_done, w_done;
        int c;
        aw_done = 0; w_done = 0; ok = 0; resp = 2'b11;
        c = 0;
        while (!(aw_done && w_done) && c < 60) begin
            @(negedge clk);
            if (aw_done) dut.axi_vip_0.inst.IF.awvalid = 1'b0;
            if (w_done)  dut.axi_vip_0.inst.IF.wvalid  = 1'b0;
            if (c == aw_dly) begin
                dut.axi_vip_0.inst.IF.awaddr  = addr;
                dut.axi_vip_0.inst.IF.awvalid = 1'b1;
            end
            if (c == w_dly) begin
                dut.axi_vip_0.inst.IF.wdata  = data;
                dut.axi_vip_0.inst.IF.wstrb  = strb;
                dut.axi_vip_0.inst.IF.wvalid = 1'b1;
            end
            if (dut.axi_vip_0.inst.IF.awvalid && dut.axi_vip_0.inst.IF.awready) aw_done = 1;
            if (dut.axi_vip_0.inst.IF.wvalid && dut.axi_vip_0.inst.IF.wready)   w_done  = 1;
            c++;
        end
        @(negedge clk);
        dut.axi_vip_0.inst.IF.awvalid = 1'b0;
        dut.axi_vip_0.inst.IF.wvalid  = 1'b0;
        dut.axi_vip_0.inst.IF.bready  = 1'b1;
        c = 0;
        while (!dut.axi_vip_0.inst.IF.bvalid && c < 60) begin
            @(negedge clk);
            c++;
        end
        if (aw_done && w_done && dut.axi_vip_0.inst.IF.bvalid) begin
            ok   = 1;
            resp = dut.axi_vip_0.inst.IF.bresp;
            b_count++;
        end
        @(negedge clk);
        dut.axi_vip_0.inst.IF.bready = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_dly, input int w_dly, input string tag);
        logic [1:0] resp;
        bit         ok;
        bit         in_range;
        in_range = (addr >> 2) < 16;
        axi_write(addr, data, strb, aw_dly, w_dly, resp, ok);
        check({tag, "_done"}, 32'(ok), 32'd1);
        check({tag, "_bresp"}, 32'(resp), in_range ? 32'h0 : 32'h2);
        if (in_range) model[addr[5:2]] = merge(model[addr[5:2]], data, strb);
    endtask

    task automatic axi_read(input logic [31:0] addr, input logic [31:0] exp_data,
                            input logic [1:0] exp_resp, input int hold, input string tag);
        rd_exp_t e;
        int      c;
        sb.push_back('{data: exp_data, resp: exp_resp});
        @(negedge clk);
        dut.axi_vip_0.inst.IF.araddr  = addr;
        dut.axi_vip_0.inst.IF.arvalid = 1'b1;
        c = 0;
        while (!dut.axi_vip_0.inst.IF.arready && c < 60) begin
            @(negedge clk);
            c++;
        end
        check({tag, "_arready"}, 32'(dut.axi_vip_0.inst.IF.arready), 32'd1);
        @(negedge clk);
        dut.axi_vip_0.inst.IF.arvalid = 1'b0;
        c = 0;
        while (!dut.axi_vip_0.inst.IF.rvalid && c < 60) begin
            @(negedge clk);
            c++;
        end
        check({tag, "_rvalid"}, 32'(dut.axi_vip_0.inst.IF.rvalid), 32'd1);
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            check({tag, "_hold_rdata"}, dut.axi_vip_0.inst.IF.rdata, sb[0].data);
            check({tag, "_hold_rvalid"}, 32'(dut.axi_vip_0.inst.IF.rvalid), 32'd1);
        end
        dut.axi_vip_0.inst.IF.rready = 1'b1;
        e = sb.pop_front();
        check({tag, "_rdata"}, dut.axi_vip_0.inst.IF.rdata, e.data);
        check({tag, "_rresp"}, 32'(dut.axi_vip_0.inst.IF.rresp), 32'(e.resp));
        r_count++;
        @(negedge clk);
        dut.axi_vip_0.inst.IF.rready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion, want summary before 1ms");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          c;
        int          b_start;
        logic [31:0] strb_exp;

        dut.axi_vip_0.inst.IF.awaddr  = '0;
        dut.axi_vip_0.inst.IF.awprot  = 3'b000;
        dut.axi_vip_0.inst.IF.awvalid = 1'b0;
        dut.axi_vip_0.inst.IF.wdata   = '0;
        dut.axi_vip_0.inst.IF.wstrb   = 4'h0;
        dut.axi_vip_0.inst.IF.wvalid  = 1'b0;
        dut.axi_vip_0.inst.IF.bready  = 1'b0;
        dut.axi_vip_0.inst.IF.araddr  = '0;
        dut.axi_vip_0.inst.IF.arprot  = 3'b000;
        dut.axi_vip_0.inst.IF.arvalid = 1'b0;
        dut.axi_vip_0.inst.IF.rready  = 1'b0;
        for (int i = 0; i < 16; i++) model[i] = '0;

        // Reset held for 100ns; outputs must sit at their reset values.
        rst_n = 1'b0;
        #100;
        check("rst_awready", 32'(dut.axi_vip_0.inst.IF.awready), 32'd0);
        check("rst_wready",  32'(dut.axi_vip_0.inst.IF.wready),  32'd0);
        check("rst_arready", 32'(dut.axi_vip_0.inst.IF.arready), 32'd0);
        check("rst_bvalid",  32'(dut.axi_vip_0.inst.IF.bvalid),  32'd0);
        check("rst_rvalid",  32'(dut.axi_vip_0.inst.IF.rvalid),  32'd0);
        check("rst_bresp",   32'(dut.axi_vip_0.inst.IF.bresp),   32'd0);
        check("rst_rresp",   32'(dut.axi_vip_0.inst.IF.rresp),   32'd0);
        check("rst_rdata",   dut.axi_vip_0.inst.IF.rdata,        32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 16; i++) axi_read(32'(4 * i), 32'd0, 2'b00, 0, "rst_rd");

        // Write i to register i, then read it back.
        b_start = b_count;
        for (int i = 0; i < 16; i++) begin
            do_write(32'(4 * i), 32'(i), 4'hF, 0, 0, "loop_wr");
            axi_read(32'(4 * i), 32'(i), 2'b00, 0, "loop_rd");
        end
        check("loop_b_count", 32'(b_count - b_start), 32'd16);
        check("loop_r_count", 32'(r_count), 32'd32);

        // AW three cycles ahead of W, then W ahead of AW.
        do_write(32'h8, 32'hDEADBEEF, 4'hF, 0, 3, "aw_first");
        repeat (3) @(negedge clk);
        check("aw_first_one_b", 32'(dut.axi_vip_0.inst.IF.bvalid), 32'd0);
        do_write(32'h8, 32'hDEADBEEF, 4'hF, 3, 0, "w_first");
        repeat (3) @(negedge clk);
        check("w_first_one_b", 32'(dut.axi_vip_0.inst.IF.bvalid), 32'd0);
        axi_read(32'h8, 32'hDEADBEEF, 2'b00, 0, "split_rd");

        // Out-of-range write and read.
        do_write(32'h40, 32'h55, 4'hF, 0, 0, "oor_wr");
        for (int i = 0; i < 16; i++) axi_read(32'(4 * i), model[i], 2'b00, 0, "oor_unchanged");
        axi_read(32'h40, 32'd0, 2'b10, 0, "oor_rd");

        // Byte-lane write onto reg0.
        do_write(32'h0, 32'h11223344, 4'hF, 0, 0, "strb_init");
        do_write(32'h0, 32'hAABBCCDD, 4'b0101, 0, 0, "strb_wr");
`ifdef DESIGN_1_WSTRB_EN
        strb_exp = 32'h11BB33DD;
`else
        strb_exp = 32'hAABBCCDD;
`endif
        axi_read(32'h0, strb_exp, 2'b00, 0, "strb_rd");

        // rready held low for 5 cycles: rdata must not move.
        axi_read(32'h8, 32'hDEADBEEF, 2'b00, 5, "hold");

        // Reset while a write response is pending.
        @(negedge clk);
        dut.axi_vip_0.inst.IF.awaddr  = 32'h4;
        dut.axi_vip_0.inst.IF.awvalid = 1'b1;
        dut.axi_vip_0.inst.IF.wdata   = 32'hCAFE0001;
        dut.axi_vip_0.inst.IF.wstrb   = 4'hF;
        dut.axi_vip_0.inst.IF.wvalid  = 1'b1;
        @(negedge clk);
        dut.axi_vip_0.inst.IF.awvalid = 1'b0;
        dut.axi_vip_0.inst.IF.wvalid  = 1'b0;
        c = 0;
        while (!dut.axi_vip_0.inst.IF.bvalid && c < 20) begin
            @(negedge clk);
            c++;
        end
        check("mid_rst_bvalid_before", 32'(dut.axi_vip_0.inst.IF.bvalid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_bvalid_drop", 32'(dut.axi_vip_0.inst.IF.bvalid), 32'd0);
        check("mid_rst_awready", 32'(dut.axi_vip_0.inst.IF.awready), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            model[i] = '0;
            axi_read(32'(4 * i), 32'd0, 2'b00, 0, "post_rst_rd");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
